psma_out_accum_serializer: RTL and testbench

- Output stage of the precision-scalable MAC array.
- Accumulates a configurable number of array result beats (output stationarity) into per-output accumulators, then drains them onto a fixed-width output bus.
- Output count, input width and repetition count are runtime-configurable per job; the bus uses valid/ready handshakes.
- Generalises the static per-mode output count/width calculation into a parametrised, sequential drain engine.

---
 rtl/psma_out_accum_serializer_if.sv | 42 ++++
 rtl/psma_out_accum_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_psma_out_accum_serializer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/psma_out_accum_serializer_if.sv
// Handshake/bus bundle for the PSMA output accumulator/serializer.
// Carries the job configuration channel, the array result input channel,
// the drain output channel and the job status flags.
//   master : job source / result sink (drives cfg_*, in_*, out_ready)
//   slave  : the accumulator/serializer
interface psma_out_accum_serializer_if #(
    parameter int unsigned MAX_OUTS = 16,
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 24,
    parameter int unsigned LANES    = 4,
    parameter int unsigned REP_W    = 10
);
    localparam int unsigned OL_W = $clog2($clog2(MAX_OUTS) + 1);
    localparam int unsigned IW_W = $clog2(IN_W + 1);

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [OL_W-1:0]           cfg_outs_log2;
    logic [IW_W-1:0]           cfg_in_w;
    logic [REP_W-1:0]          cfg_rep;
    logic                      in_valid;
    logic                      in_ready;
    logic [MAX_OUTS*IN_W-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*OUT_W-1:0]    out_data;
    logic                      out_last;
    logic                      ovf;
    logic                      busy;

    modport master (
        output cfg_valid, cfg_outs_log2, cfg_in_w, cfg_rep,
        output in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_last, ovf, busy
    );

    modport slave (
        input  cfg_valid, cfg_outs_log2, cfg_in_w, cfg_rep,
        input  in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_last, ovf, busy
    );
endinterface

// File: rtl/psma_out_accum_serializer.sv
// Output stage of the precision-scalable MAC array.
// Accumulates R array result beats into N per-output accumulators, then
// drains them LANES at a time onto the output bus.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : cfg_* job config (accepted in IDLE), in_* result beats
//                (accepted in ACCUM), out_* drain beats, ovf/busy status
module psma_out_accum_serializer #(
    parameter int unsigned MAX_OUTS = 16,
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 24,
    parameter int unsigned LANES    = 4,
    parameter int unsigned REP_W    = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    psma_out_accum_serializer_if.slave     bus
);
    localparam int unsigned OL_W    = $clog2($clog2(MAX_OUTS) + 1);
    localparam int unsigned IW_W    = $clog2(IN_W + 1);
    localparam int unsigned LOG_MAX = $clog2(MAX_OUTS);
    localparam int unsigned N_W     = LOG_MAX + 1;
    localparam int unsigned IDX_W   = (LOG_MAX > 0) ? LOG_MAX : 1;
    localparam int unsigned BEATS   = MAX_OUTS / LANES;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                   state, state_nxt;

    // captured job configuration
    logic [N_W-1:0]           n_outs;
    logic [IW_W-1:0]          w_in;
    logic [REP_W-1:0]         rep_m1;
    logic [BEAT_W-1:0]        last_beat;

    logic [REP_W-1:0]         rep_cnt;
    logic [BEAT_W-1:0]        beat;
    logic [OUT_W-1:0]         acc     [MAX_OUTS];
    logic [OUT_W-1:0]         acc_nxt [MAX_OUTS];
    logic [OUT_W-1:0]         acc_sum [MAX_OUTS];
    logic [OUT_W-1:0]         lane_ext[MAX_OUTS];
    logic                     ovf_add;

    logic                     cfg_ready_q, in_ready_q, out_valid_q, out_last_q;
    logic                     ovf_q, busy_q;
    logic [LANES*OUT_W-1:0]   out_data_q;

    logic [OL_W-1:0]          cfg_log2;
    logic [N_W-1:0]           cfg_n;
    logic [IW_W-1:0]          cfg_w;
    logic [REP_W-1:0]         cfg_rep_m1;
    logic [BEAT_W-1:0]        cfg_last_beat;

    logic                     cfg_fire, in_fire, out_fire, in_last;
    logic [BEAT_W-1:0]        sel_beat;
    logic [IDX_W-1:0]         sel_idx;
    logic [LANES*OUT_W-1:0]   sel_data;

    // Keep the low w bits of a lane, sign-extended to the accumulator width.
    function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] v,
                                              input logic [IW_W-1:0] w);
        logic [IW_W-1:0]        sh;
        logic signed [IN_W-1:0] t;
        sh = IW_W'(IN_W) - w;
        t  = v << sh;
        t  = t >>> sh;
        return OUT_W'(t);
    endfunction

    assign cfg_fire = (state == IDLE) && bus.cfg_valid && cfg_ready_q;
    assign in_fire  = (state == ACCUM) && bus.in_valid;
    assign in_last  = (rep_cnt == rep_m1);
    assign out_fire = (state == DRAIN) && out_valid_q && bus.out_ready;

    // Configuration clamping
    always_comb begin
        cfg_log2 = bus.cfg_outs_log2;
        if (bus.cfg_outs_log2 > OL_W'(LOG_MAX)) cfg_log2 = OL_W'(LOG_MAX);
        cfg_n = N_W'(1) << cfg_log2;
        cfg_w = bus.cfg_in_w;
        if ((bus.cfg_in_w == '0) || (bus.cfg_in_w > IW_W'(IN_W))) cfg_w = IW_W'(IN_W);
        cfg_rep_m1 = (bus.cfg_rep == '0) ? '0 : bus.cfg_rep - 1'b1;
        cfg_last_beat = '0;
        if (cfg_n > N_W'(LANES)) cfg_last_beat = BEAT_W'(cfg_n / N_W'(LANES) - N_W'(1));
    end

    // Accumulate datapath: first beat of a job loads, later beats add
    always_comb begin
        ovf_add = 1'b0;
        for (int i = 0; i < MAX_OUTS; i++) begin
            lane_ext[i] = sext(bus.in_data[i*IN_W +: IN_W], w_in);
            acc_sum[i]  = acc[i] + lane_ext[i];
            acc_nxt[i]  = acc[i];
            if (N_W'(i) < n_outs) begin
                if (rep_cnt == '0) begin
                    acc_nxt[i] = lane_ext[i];
                end else begin
                    acc_nxt[i] = acc_sum[i];
                    if ((acc[i][OUT_W-1] == lane_ext[i][OUT_W-1]) &&
                        (acc_sum[i][OUT_W-1] != acc[i][OUT_W-1]))
                        ovf_add = 1'b1;
                end
            end
        end
    end

    // Next drain beat: beat 0 of the freshly updated accumulators when
    // leaving ACCUM, otherwise the beat after the current one.
    always_comb begin
        sel_beat = (state == ACCUM) ? '0 : BEAT_W'(beat + 1'b1);
        sel_data = '0;
        sel_idx  = '0;
        for (int j = 0; j < LANES; j++) begin
            sel_idx = IDX_W'(int'(sel_beat) * int'(LANES) + j);
            if (N_W'(sel_idx) < n_outs)
                sel_data[j*OUT_W +: OUT_W] = (state == ACCUM) ? acc_nxt[sel_idx] : acc[sel_idx];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_fire)               state_nxt = ACCUM;
            ACCUM:   if (in_fire && in_last)     state_nxt = DRAIN;
            DRAIN:   if (out_fire && out_last_q) state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            n_outs      <= '0;
            w_in        <= '0;
            rep_m1      <= '0;
            last_beat   <= '0;
            rep_cnt     <= '0;
            beat        <= '0;
            for (int i = 0; i < MAX_OUTS; i++) acc[i] <= '0;
        end else begin
            cfg_ready_q <= (state_nxt == IDLE);
            in_ready_q  <= (state_nxt == ACCUM);
            out_valid_q <= (state_nxt == DRAIN);
            busy_q      <= (state_nxt != IDLE);

            if (cfg_fire) begin
                n_outs    <= cfg_n;
                w_in      <= cfg_w;
                rep_m1    <= cfg_rep_m1;
                last_beat <= cfg_last_beat;
                rep_cnt   <= '0;
                ovf_q     <= 1'b0;
            end

            if (in_fire) begin
                for (int i = 0; i < MAX_OUTS; i++) acc[i] <= acc_nxt[i];
                ovf_q   <= ovf_q | ovf_add;
                rep_cnt <= in_last ? '0 : rep_cnt + 1'b1;
                if (in_last) begin
                    out_data_q <= sel_data;
                    out_last_q <= (cfg_last_beat == '0) ? (last_beat == '0) : (last_beat == '0);
                    beat       <= '0;
                end
            end

            if (out_fire) begin
                if (out_last_q) begin
                    out_last_q <= 1'b0;
                    out_data_q <= '0;
                end else begin
                    beat       <= BEAT_W'(beat + 1'b1);
                    out_data_q <= sel_data;
                    out_last_q <= (BEAT_W'(beat + 1'b1) == last_beat);
                end
            end
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_psma_out_accum_serializer.sv
// Bench for psma_out_accum_serializer: table of directed jobs with
// hand-computed accumulator results, plus a mid-job reset sequence.
module tb_psma_out_accum_serializer;
    localparam int unsigned MAX_OUTS = 16;
    localparam int unsigned IN_W     = 16;
    localparam int unsigned OUT_W    = 24;
    localparam int unsigned LANES    = 4;
    localparam int unsigned REP_W    = 10;
    localparam int          NJOBS    = 7;

    typedef struct {
        int log2;
        int in_w;
        int rep;
        int lanes[16];
        int exp_acc[16];
        int exp_beats;
        int exp_ovf;
        int stall_beat;
        int stall_cycles;
    } job_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    job_t jobs[NJOBS];

    psma_out_accum_serializer_if #(
        .MAX_OUTS(MAX_OUTS), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .REP_W(REP_W)
    ) bus ();

    psma_out_accum_serializer #(
        .MAX_OUTS(MAX_OUTS), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .REP_W(REP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic job_t blank_job();
        job_t j;
        j.log2 = 0; j.in_w = 16; j.rep = 1;
        for (int i = 0; i < 16; i++) begin
            j.lanes[i]   = 0;
            j.exp_acc[i] = 0;
        end
        j.exp_beats = 1; j.exp_ovf = 0; j.stall_beat = -1; j.stall_cycles = 0;
        return j;
    endfunction

    task automatic run_job(input job_t j, input int id);
        int cnt;
        int accepted;
        int need;
        logic [LANES*OUT_W-1:0] held;
        string tag;
        tag = $sformatf("job%0d", id);

        cnt = 0;
        while (!bus.cfg_ready && cnt < 100) begin @(negedge clk); cnt++; end
        chk({tag, " cfg_ready"}, int'(bus.cfg_ready), 1);

        bus.cfg_outs_log2 = 3'(j.log2);
        bus.cfg_in_w      = 5'(j.in_w);
        bus.cfg_rep       = 10'(j.rep);
        bus.cfg_valid     = 1'b1;
        @(negedge clk);
        bus.cfg_valid     = 1'b0;
        chk({tag, " busy after cfg"}, int'(bus.busy), 1);
        chk({tag, " in_ready after cfg"}, int'(bus.in_ready), 1);
        chk({tag, " ovf cleared"}, int'(bus.ovf), 0);
        chk({tag, " cfg_ready low"}, int'(bus.cfg_ready), 0);

        for (int i = 0; i < 16; i++) bus.in_data[i*IN_W +: IN_W] = 16'(j.lanes[i]);
        need = (j.rep == 0) ? 1 : j.rep;
        accepted = 0;
        cnt = 0;
        while (accepted < need && cnt < 100) begin
            if (bus.in_ready) begin
                bus.in_valid = 1'b1;
                @(negedge clk);
                accepted++;
            end else begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                cnt++;
            end
        end
        bus.in_valid = 1'b0;
        chk({tag, " beats accepted"}, accepted, need);
        chk({tag, " out_valid latency"}, int'(bus.out_valid), 1);
        chk({tag, " in_ready in drain"}, int'(bus.in_ready), 0);

        for (int b = 0; b < j.exp_beats; b++) begin
            cnt = 0;
            while (!bus.out_valid && cnt < 100) begin @(negedge clk); cnt++; end
            chk($sformatf("%s beat%0d out_valid", tag, b), int'(bus.out_valid), 1);
            if (b == j.stall_beat) begin
                bus.out_ready = 1'b0;
                held = bus.out_data;
                repeat (j.stall_cycles) begin
                    @(negedge clk);
                    chk($sformatf("%s beat%0d hold data", tag, b), int'(bus.out_data == held), 1);
                    chk($sformatf("%s beat%0d hold valid", tag, b), int'(bus.out_valid), 1);
                end
            end
            for (int l = 0; l < LANES; l++)
                chk($sformatf("%s beat%0d lane%0d", tag, b, l),
                    int'($signed(bus.out_data[l*OUT_W +: OUT_W])), j.exp_acc[b*LANES+l]);
            chk($sformatf("%s beat%0d out_last", tag, b), int'(bus.out_last),
                int'(b == j.exp_beats - 1));
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        chk({tag, " out_valid after drain"}, int'(bus.out_valid), 0);
        chk({tag, " busy after drain"}, int'(bus.busy), 0);
        chk({tag, " cfg_ready after drain"}, int'(bus.cfg_ready), 1);
        chk({tag, " ovf"}, int'(bus.ovf), j.exp_ovf);
    endtask

    initial begin
        job_t jr;

        rst_n             = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_outs_log2 = '0;
        bus.cfg_in_w      = '0;
        bus.cfg_rep       = '0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.out_ready     = 1'b0;

        // N=4, 16-bit, R=3
        jobs[0] = blank_job();
        jobs[0].log2 = 2; jobs[0].rep = 3;
        jobs[0].lanes[0] = 100; jobs[0].lanes[1] = -50; jobs[0].lanes[2] = 7;
        jobs[0].lanes[4] = 1234;
        jobs[0].exp_acc[0] = 300; jobs[0].exp_acc[1] = -150; jobs[0].exp_acc[2] = 21;

        // N=16, 8-bit, R=1, stall on beat 1
        jobs[1] = blank_job();
        jobs[1].log2 = 4; jobs[1].in_w = 8; jobs[1].exp_beats = 4;
        jobs[1].stall_beat = 1; jobs[1].stall_cycles = 3;
        jobs[1].lanes[0] = 'h00FF; jobs[1].exp_acc[0] = -1;
        for (int i = 1; i < 16; i++) begin
            jobs[1].lanes[i] = i; jobs[1].exp_acc[i] = i;
        end

        // N=1, R=257 of 0x7FFF: wraps and overflows
        jobs[2] = blank_job();
        jobs[2].rep = 257; jobs[2].exp_ovf = 1;
        jobs[2].lanes[0] = 'h7FFF; jobs[2].exp_acc[0] = -8356097;
        for (int i = 1; i < 16; i++) jobs[2].lanes[i] = 999;

        // zero/over-range config clamps to R=1, W=16, N=16
        jobs[3] = blank_job();
        jobs[3].log2 = 7; jobs[3].in_w = 0; jobs[3].rep = 0; jobs[3].exp_beats = 4;
        for (int i = 0; i < 16; i++) begin
            jobs[3].lanes[i] = 'hFF00 | i; jobs[3].exp_acc[i] = -256 + i;
        end

        // N=2: lanes 2,3 of the beat are zero
        jobs[4] = blank_job();
        jobs[4].log2 = 1; jobs[4].rep = 2;
        jobs[4].lanes[0] = 11; jobs[4].lanes[1] = 22; jobs[4].lanes[2] = 33; jobs[4].lanes[3] = 44;
        jobs[4].exp_acc[0] = 22; jobs[4].exp_acc[1] = 44;

        // in_w above IN_W clamps to 16
        jobs[5] = blank_job();
        jobs[5].in_w = 20; jobs[5].lanes[0] = 'h8001; jobs[5].exp_acc[0] = -32767;

        // 4-bit lanes: 0x9 -> -7, twice
        jobs[6] = blank_job();
        jobs[6].in_w = 4; jobs[6].rep = 2; jobs[6].lanes[0] = 'h0019; jobs[6].exp_acc[0] = -14;

        repeat (3) @(negedge clk);
        chk("reset in_ready", int'(bus.in_ready), 0);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out_last", int'(bus.out_last), 0);
        chk("reset ovf", int'(bus.ovf), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset out_data", int'(bus.out_data != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset cfg_ready", int'(bus.cfg_ready), 1);

        for (int k = 0; k < NJOBS; k++) run_job(jobs[k], k);

        // reset in the middle of ACCUM
        bus.cfg_outs_log2 = 3'd2;
        bus.cfg_in_w      = 5'd16;
        bus.cfg_rep       = 10'd5;
        bus.cfg_valid     = 1'b1;
        @(negedge clk);
        bus.cfg_valid     = 1'b0;
        bus.in_data       = '0;
        bus.in_data[15:0] = 16'd1000;
        bus.in_valid      = 1'b1;
        repeat (2) @(negedge clk);
        chk("midjob in_ready before reset", int'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midjob reset in_ready", int'(bus.in_ready), 0);
        chk("midjob reset out_valid", int'(bus.out_valid), 0);
        chk("midjob reset busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midjob cfg_ready after release", int'(bus.cfg_ready), 1);

        jr = blank_job();
        jr.lanes[0] = 5; jr.exp_acc[0] = 5;
        run_job(jr, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
